ifetch_unit: RTL

Instruction fetch stage directly downstream of the PC register. It takes the current PC and issues a word-aligned read to instruction memory over a request/grant + response-valid handshake that tolerates variable latency. It holds the returned instruction in an output register until the decode stage accepts it, then pulses `pc_en` so the PC register loads NPC. It also reports misaligned fetches and supports a flush that discards in-flight fetches.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
//   state_e          - fetch FSM states
//   WORD_MASK        - clears the byte-offset bits of a PC to form a word address
//   NOP_INST_DEFAULT - default instruction word shown when no valid fetch is held
package ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_e;

   localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;
   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage sitting right after the PC register.
// Issues one word-aligned read per PC over a req/gnt + rvalid handshake,
// holds the result until decode accepts it, then raises pc_en so the PC
// register advances. Misaligned PCs produce an errored NOP without any
// memory traffic. flush discards whatever is in flight or held.
//
// Ports
//   clock, reset       - rising-edge clock, async active-high reset
//   PC                 - current program counter
//   flush              - drop current/held fetch and restart from PC
//   imem_req/addr/gnt  - request channel to instruction memory
//   imem_rvalid/rdata  - response channel from instruction memory
//   inst_valid/inst/inst_pc/inst_err - registered fetch result to decode
//   inst_ready         - decode accepts the held instruction
//   pc_en              - PC register load enable
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] PC,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_err,
   input  logic        inst_ready,
   output logic        pc_en
);

   state_e      state_q,      state_d;
   logic [31:0] inst_q,       inst_d;
   logic [31:0] inst_pc_q,    inst_pc_d;
   logic        inst_err_q,   inst_err_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] req_pc_q,     req_pc_d;
   logic        drop_q,       drop_d;

   logic        pc_aligned;

   assign pc_aligned = (PC[1:0] == 2'b00);

   // PC is held by the upstream register until pc_en, so the address is
   // stable for as long as the request is pending.
   assign imem_addr  = PC & WORD_MASK;

   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_err   = inst_err_q;
   assign inst_valid = inst_valid_q;

   always_comb begin
      state_d      = state_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_err_d   = inst_err_q;
      inst_valid_d = inst_valid_q;
      req_pc_d     = req_pc_q;
      drop_d       = drop_q;
      imem_req     = 1'b0;
      pc_en        = 1'b0;

      case (state_q)
         IDLE: state_d = REQ;

         REQ: begin
            if (flush) begin
               // Request is suppressed so no grant can be taken for a
               // fetch we are about to abandon.
               inst_valid_d = 1'b0;
            end else if (!pc_aligned) begin
               inst_d       = NOP_INST;
               inst_pc_d    = PC;
               inst_err_d   = 1'b1;
               inst_valid_d = 1'b1;
               state_d      = HOLD;
            end else begin
               imem_req = 1'b1;
               if (imem_gnt) begin
                  req_pc_d = PC;
                  state_d  = WAIT;
               end
            end
         end

         WAIT: begin
            if (flush) begin
               // The granted response still has to arrive; remember to
               // swallow it unless it is arriving right now.
               if (imem_rvalid) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  inst_d       = imem_rdata;
                  inst_pc_d    = req_pc_q;
                  inst_err_d   = 1'b0;
                  inst_valid_d = 1'b1;
                  state_d      = HOLD;
               end
            end
         end

         HOLD: begin
            pc_en = inst_ready & ~flush;
            if (flush || inst_ready) begin
               inst_d       = NOP_INST;
               inst_err_d   = 1'b0;
               inst_valid_d = 1'b0;
               state_d      = REQ;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         inst_q       <= NOP_INST;
         inst_pc_q    <= 32'h0;
         inst_err_q   <= 1'b0;
         inst_valid_q <= 1'b0;
         req_pc_q     <= 32'h0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_err_q   <= inst_err_d;
         inst_valid_q <= inst_valid_d;
         req_pc_q     <= req_pc_d;
         drop_q       <= drop_d;
      end
   end

endmodule
